// File: rtl/gt_phy_pkg.sv
// Shared definitions for the GT receive PHY: comma symbol, lane count,
// alignment state encoding and saturating counter helpers.
package gt_phy_pkg;

    localparam logic [7:0] K28_5     = 8'hBC;
    localparam int         NUM_LANES = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gt_byte_rotate.sv
// Byte-offset rotator: registers the previous raw word and selects a 4-byte
// window spanning previous/current words; output is registered (2-cycle latency).
module gt_byte_rotate
    import gt_phy_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [8*NUM_LANES-1:0]   i_data,
    input  logic [NUM_LANES-1:0]     i_charisk,
    input  logic [1:0]               i_offset,
    output logic [8*NUM_LANES-1:0]   o_data,
    output logic [NUM_LANES-1:0]     o_charisk
);

    logic [8*NUM_LANES-1:0] r_prev_data;
    logic [NUM_LANES-1:0]   r_prev_k;
    logic [8*NUM_LANES-1:0] r_data;
    logic [NUM_LANES-1:0]   r_k;
    logic [8*NUM_LANES-1:0] w_data;
    logic [NUM_LANES-1:0]   w_k;

    // Window starts at byte <offset> of the previous word
    always_comb begin
        w_data = r_prev_data;
        w_k    = r_prev_k;
        case (i_offset)
            2'd0: begin
                w_data = r_prev_data;
                w_k    = r_prev_k;
            end
            2'd1: begin
                w_data = {i_data[7:0], r_prev_data[31:8]};
                w_k    = {i_charisk[0], r_prev_k[3:1]};
            end
            2'd2: begin
                w_data = {i_data[15:0], r_prev_data[31:16]};
                w_k    = {i_charisk[1:0], r_prev_k[3:2]};
            end
            2'd3: begin
                w_data = {i_data[23:0], r_prev_data[31:24]};
                w_k    = {i_charisk[2:0], r_prev_k[3]};
            end
            default: begin
                w_data = r_prev_data;
                w_k    = r_prev_k;
            end
        endcase
    end

    // Previous-word capture and output register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_prev_data <= '0;
            r_prev_k    <= '0;
            r_data      <= '0;
            r_k         <= '0;
        end else begin
            r_prev_data <= i_data;
            r_prev_k    <= i_charisk;
            r_data      <= w_data;
            r_k         <= w_k;
        end
    end

    assign o_data    = r_data;
    assign o_charisk = r_k;

endmodule

// File: rtl/gt_rx_byte_align.sv
// K28.5 comma byte aligner: hunt/verify/locked FSM choosing the byte offset,
// with loss detection on repeated misaligned commas or a comma gap.
module gt_rx_byte_align
    import gt_phy_pkg::*;
#(
    parameter logic [7:0]  COMMA    = K28_5,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned GAP_MAX  = 1024
)(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_gt_rx_data,
    input  logic [3:0]  i_gt_rx_charisk,
    input  logic        i_gt_reset_done,
    output logic [31:0] o_gt_rx_data,
    output logic [3:0]  o_gt_rx_charisk,
    output logic        o_gt_bytealign,
    output logic [1:0]  o_align_offset,
    output logic        o_realign_pulse
);

    localparam logic [3:0]  LOCK_LAST = 4'(LOCK_CNT - 1);
    localparam logic [3:0]  LOSS_LAST = 4'(LOSS_CNT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_MAX - 1);

    align_state_e r_state, w_state_nxt;
    logic [1:0]   r_offset, w_offset_nxt;
    logic [3:0]   r_cnt, w_cnt_nxt;
    logic [3:0]   r_err, w_err_nxt;
    logic [15:0]  r_gap, w_gap_nxt;
    logic         r_bytealign;
    logic         r_realign;
    logic [3:0]   w_hit;
    logic [1:0]   w_first;
    logic         w_any;
    logic         w_aligned;
    logic         w_lost;

    // Per-lane comma detection on the raw word
    always_comb begin
        w_hit = 4'b0000;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_hit[k] = (i_gt_rx_data[8*k +: 8] == COMMA) && i_gt_rx_charisk[k];
        end
    end

    // Lowest lane carrying a comma
    always_comb begin
        casez (w_hit)
            4'b???1: w_first = 2'd0;
            4'b??10: w_first = 2'd1;
            4'b?100: w_first = 2'd2;
            4'b1000: w_first = 2'd3;
            default: w_first = 2'd0;
        endcase
    end

    assign w_any     = |w_hit;
    assign w_aligned = w_hit[r_offset];
    assign w_lost    = (w_any && (r_err == LOSS_LAST)) || (r_gap == GAP_LAST);

    // Next-state and counter logic
    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
        w_gap_nxt    = r_gap;
        if (!i_gt_reset_done) begin
            w_state_nxt = HUNT;
            w_cnt_nxt   = 4'd0;
            w_err_nxt   = 4'd0;
            w_gap_nxt   = 16'd0;
        end else begin
            case (r_state)
                HUNT: begin
                    if (w_any) begin
                        w_offset_nxt = w_first;
                        w_cnt_nxt    = 4'd1;
                        w_err_nxt    = 4'd0;
                        w_gap_nxt    = 16'd0;
                        w_state_nxt  = (LOCK_CNT == 32'd1) ? LOCKED : VERIFY;
                    end else begin
                        w_cnt_nxt = 4'd0;
                    end
                end
                VERIFY: begin
                    if (w_aligned) begin
                        w_gap_nxt = 16'd0;
                        w_cnt_nxt = sat_inc4(r_cnt);
                        if (r_cnt == LOCK_LAST) begin
                            w_state_nxt = LOCKED;
                            w_err_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = VERIFY;
                        end
                    end else if (w_any) begin
                        w_offset_nxt = w_first;
                        w_cnt_nxt    = 4'd1;
                        w_gap_nxt    = 16'd0;
                    end else if (r_gap == GAP_LAST) begin
                        w_state_nxt = HUNT;
                        w_cnt_nxt   = 4'd0;
                        w_gap_nxt   = 16'd0;
                    end else begin
                        w_gap_nxt = sat_inc16(r_gap);
                    end
                end
                LOCKED: begin
                    if (w_aligned) begin
                        w_err_nxt = 4'd0;
                        w_gap_nxt = 16'd0;
                    end else if (w_lost) begin
                        // err and gap exhaustion together still yield one exit
                        w_state_nxt = HUNT;
                        w_cnt_nxt   = 4'd0;
                        w_err_nxt   = 4'd0;
                        w_gap_nxt   = 16'd0;
                    end else begin
                        w_gap_nxt = sat_inc16(r_gap);
                        w_err_nxt = w_any ? sat_inc4(r_err) : r_err;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_cnt_nxt   = 4'd0;
                    w_err_nxt   = 4'd0;
                    w_gap_nxt   = 16'd0;
                end
            endcase
        end
    end

    // State, counters and registered status outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= HUNT;
            r_offset    <= 2'd0;
            r_cnt       <= 4'd0;
            r_err       <= 4'd0;
            r_gap       <= 16'd0;
            r_bytealign <= 1'b0;
            r_realign   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_offset    <= w_offset_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_gap       <= w_gap_nxt;
            r_bytealign <= (w_state_nxt == LOCKED);
            r_realign   <= (r_state == LOCKED) && (w_state_nxt != LOCKED);
        end
    end

    gt_byte_rotate u_rotate (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_data    (i_gt_rx_data),
        .i_charisk (i_gt_rx_charisk),
        .i_offset  (r_offset),
        .o_data    (o_gt_rx_data),
        .o_charisk (o_gt_rx_charisk)
    );

    assign o_gt_bytealign  = r_bytealign;
    assign o_align_offset  = r_offset;
    assign o_realign_pulse = r_realign;

endmodule
